// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM state encoding and address-map helpers.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

  // Wait counter width covers WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w_of(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between requester and memory completer.
// APB_MEM_PSTRB_EN adds the APB4 write-strobe lane enables.
interface apb_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
`ifdef APB_MEM_PSTRB_EN
  logic [DATA_W/8-1:0] PSTRB;
`endif
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

`ifdef APB_MEM_PSTRB_EN
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
`else
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
`endif

endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W RAM: synchronous per-byte write, registered read port.
// The read register doubles as the completer's PRDATA register.
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_be,
  input  logic                i_rd_en,
  input  logic                i_rd_clr,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [DATA_W-1:0]   o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_q;

  always_ff @(posedge PCLK) begin
    if (i_wr_en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (i_wr_be[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  // Clear takes priority so an erroneous read returns zero.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)      r_rd_q <= '0;
    else if (i_rd_clr) r_rd_q <= '0;
    else if (i_rd_en)  r_rd_q <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_rd_q;

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer fronting a word-addressed RAM with a base-address window,
// programmable wait states and PSLVERR. APB_MEM_PSTRB_EN enables write strobes.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input logic              PCLK,
  input logic              PRESETn,
  apb_mem_slave_if.slave   apb
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = lsb_of(DATA_W);
  localparam int IDX_W = idx_w_of(DEPTH);
  localparam logic [ADDR_W:0]    SPAN     = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0]  LSB_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);
  localparam logic [CNT_W-1:0]   WS_M1    = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  apb_state_e          r_state;
  apb_state_e          w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                r_write;
  logic                r_err;
  logic                r_pready;
  logic                r_pslverr;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [BYTES-1:0]    w_wr_be;

  logic [ADDR_W:0]     w_off;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;
  logic                w_setup;
  logic                w_next_err;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_rd_clr;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [DATA_W-1:0]   w_rd_q;

  // Decode: extra MSB of the offset flags addresses below the window.
  assign w_off   = {1'b0, apb.PADDR} - {1'b0, BASE_ADDR};
  assign w_err   = w_off[ADDR_W] || (w_off >= SPAN) || (|(apb.PADDR & LSB_MASK));
  assign w_idx   = w_off[LSB +: IDX_W];
  assign w_setup = apb.PSEL && !apb.PENABLE;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_pready  <= (w_next == READY);
      r_pslverr <= (w_next == READY) && w_next_err;
      if (r_state == IDLE && w_setup) begin
        r_write <= apb.PWRITE;
        r_err   <= w_err;
      end
    end
  end

  // Transfer payload: captured at setup, needs no reset.
  always_ff @(posedge PCLK) begin
    if (r_state == IDLE && w_setup) begin
      r_idx   <= w_idx;
      r_wdata <= apb.PWDATA;
    end
  end

`ifdef APB_MEM_PSTRB_EN
  logic [BYTES-1:0] r_strb;

  always_ff @(posedge PCLK) begin
    if (r_state == IDLE && w_setup) r_strb <= apb.PSTRB;
  end

  assign w_wr_be = r_strb;
`else
  assign w_wr_be = '1;
`endif

  assign w_next_err = (r_state == IDLE) ? w_err : r_err;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_wr_en    = 1'b0;
    w_rd_en    = 1'b0;
    w_rd_clr   = 1'b0;
    w_rd_idx   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          if (WAIT_STATES == 0) begin
            w_next   = READY;
            w_rd_idx = w_idx;
            if (!apb.PWRITE) begin
              w_rd_clr = w_err;
              w_rd_en  = !w_err;
            end
          end else begin
            w_next     = WAIT;
            w_cnt_next = WS_M1;
          end
        end
      end
      WAIT: begin
        if (!apb.PSEL) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end else if (r_cnt == '0) begin
          w_next = READY;
          if (!r_write) begin
            w_rd_clr = r_err;
            w_rd_en  = !r_err;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      READY: begin
        w_next  = IDLE;
        w_wr_en = apb.PSEL && r_write && !r_err;
      end
      default: w_next = IDLE;
    endcase
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_wdata),
    .i_wr_be   (w_wr_be),
    .i_rd_en   (w_rd_en),
    .i_rd_clr  (w_rd_clr),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_q)
  );

  assign apb.PRDATA  = w_rd_q;
  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized bench for apb_mem_slave: two instances (0 and 3 wait states)
// checked against an address-map/memory reference model.
module tb_apb_mem_slave;

  localparam int DEPTH = 16;
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) a0 ();
  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) a1 ();

  assign a0.PSEL = psel[0];    assign a1.PSEL = psel[1];
  assign a0.PENABLE = penable[0]; assign a1.PENABLE = penable[1];
  assign a0.PWRITE = pwrite[0];  assign a1.PWRITE = pwrite[1];
  assign a0.PADDR = paddr[0];    assign a1.PADDR = paddr[1];
  assign a0.PWDATA = pwdata[0];  assign a1.PWDATA = pwdata[1];
`ifdef APB_MEM_PSTRB_EN
  assign a0.PSTRB = pstrb[0];    assign a1.PSTRB = pstrb[1];
`endif
  assign prdata[0] = a0.PRDATA;  assign prdata[1] = a1.PRDATA;
  assign pready[0] = a0.PREADY;  assign pready[1] = a1.PREADY;
  assign pslverr[0] = a0.PSLVERR; assign pslverr[1] = a1.PSLVERR;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH),
                  .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0))
    u_dut0 (.PCLK(clk), .PRESETn(rstn), .apb(a0));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH),
                  .BASE_ADDR(32'h0000_0400), .WAIT_STATES(3))
    u_dut1 (.PCLK(clk), .PRESETn(rstn), .apb(a1));

  logic [31:0] base [2] = '{32'h0000_0000, 32'h0000_0400};
  int          ws   [2] = '{0, 3};
  logic [31:0] mem  [2][DEPTH];
  logic [31:0] last [2];

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_err(input int i, input logic [31:0] a);
    return (a < base[i]) || (a >= base[i] + SPAN) || (a[1:0] != 2'b00);
  endfunction

  function automatic int exp_idx(input int i, input logic [31:0] a);
    return int'((a - base[i]) >> 2);
  endfunction

  // One complete APB transfer; leaves the bus in the access phase so a
  // following call makes a back-to-back transfer.
  task automatic xfer(input int i, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int          waits;
    bit          e;
    logic [31:0] erd;
    logic [3:0]  be;
    @(negedge clk);
    check("rdy_low_at_setup", 64'(pready[i]), 64'(0));
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr;
    paddr[i] = a; pwdata[i] = d; pstrb[i] = s;
    @(negedge clk);
    penable[i] = 1'b1;
    waits = 0;
    while (pready[i] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    e = exp_err(i, a);
    check("wait_cycles", 64'(waits), 64'(ws[i]));
    check("pslverr", 64'(pslverr[i]), 64'(e));
    if (!wr) begin
      erd = e ? 32'h0 : mem[i][exp_idx(i, a)];
      last[i] = erd;
      check("rdata", 64'(prdata[i]), 64'(erd));
    end else begin
      check("rdata_hold", 64'(prdata[i]), 64'(last[i]));
`ifdef APB_MEM_PSTRB_EN
      be = s;
`else
      be = 4'hF;
`endif
      if (!e) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[i][exp_idx(i, a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    psel[i] = 1'b0; penable[i] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0;
      paddr[i] = 0; pwdata[i] = 0; pstrb[i] = 4'hF; last[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_pready", 64'(pready[i]), 64'(0));
      check("rst_pslverr", 64'(pslverr[i]), 64'(0));
      check("rst_prdata", 64'(prdata[i]), 64'(0));
    end
    rstn = 1'b1;

    // Fill both memories so every later read has a known value.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++)
        xfer(i, 1, base[i] + 32'(k * 4), $urandom, 4'hF);
      idle(i);
    end

    // Write then read with no wait states.
    xfer(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 0, 32'h10, 32'h0, 4'hF);
    check("deadbeef", 64'(prdata[0]), 64'h0000_0000_DEAD_BEEF);
    idle(0);

    // Three wait states, then a back-to-back setup.
    xfer(1, 0, base[1] + 32'h04, 32'h0, 4'hF);
    xfer(1, 0, base[1] + 32'h08, 32'h0, 4'hF);
    idle(1);

    // Error responses: beyond the window, misaligned, below the window.
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1, base[i] + SPAN, 32'hBAD0_0001, 4'hF);
      xfer(i, 0, base[i] + SPAN, 32'h0, 4'hF);
      check("err_read_zero", 64'(prdata[i]), 64'(0));
      xfer(i, 1, base[i] + 32'h02, 32'hBAD0_0002, 4'hF);
      xfer(i, 0, base[i] + 32'h02, 32'h0, 4'hF);
      xfer(i, 0, base[i] + 32'h00, 32'h0, 4'hF);
      xfer(i, 0, base[i] + 32'h04, 32'h0, 4'hF);
      idle(i);
    end
    xfer(1, 1, base[1] - 32'h4, 32'hBAD0_0003, 4'hF);
    xfer(1, 0, base[1] - 32'h4, 32'h0, 4'hF);
    idle(1);

    // First and last word, no aliasing.
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1, base[i], 32'hA5A5_0000, 4'hF);
      xfer(i, 1, base[i] + SPAN - 32'h4, 32'h5A5A_FFFF, 4'hF);
      xfer(i, 0, base[i], 32'h0, 4'hF);
      check("idx0", 64'(prdata[i]), 64'h0000_0000_A5A5_0000);
      xfer(i, 0, base[i] + SPAN - 32'h4, 32'h0, 4'hF);
      check("idx_last", 64'(prdata[i]), 64'h0000_0000_5A5A_FFFF);
      idle(i);
    end

`ifdef APB_MEM_PSTRB_EN
    xfer(0, 1, 32'h20, 32'h1122_3344, 4'hF);
    xfer(0, 1, 32'h20, 32'hAABB_CCDD, 4'b0101);
    xfer(0, 0, 32'h20, 32'h0, 4'b0000);
    check("strobe_merge", 64'(prdata[0]), 64'h0000_0000_11BB_33DD);
    xfer(0, 1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
    xfer(0, 0, 32'h20, 32'h0, 4'hF);
    check("strobe_zero", 64'(prdata[0]), 64'h0000_0000_11BB_33DD);
    idle(0);
`endif

    // PENABLE without a setup phase is ignored.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h18;
    pwdata[0] = 32'hFEED_0000;
    repeat (2) begin
      @(negedge clk);
      check("no_setup_ready", 64'(pready[0]), 64'(0));
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 0, 32'h18, 32'h0, 4'hF);
    idle(0);

    // PSEL dropped during wait states aborts the write.
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = base[1] + 32'h20; pwdata[1] = 32'hC0DE_C0DE;
    @(negedge clk);
    psel[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_ready", 64'(pready[1]), 64'(0));
    end
    xfer(1, 0, base[1] + 32'h20, 32'h0, 4'hF);
    idle(1);

    // Randomized traffic around and inside each window.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 80; k++) begin
        a = base[i] + 32'($urandom_range(0, DEPTH * 4 + 15)) - 32'h8;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        d = $urandom;
        xfer(i, 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 4) == 0) idle(i);
      end
      idle(i);
    end

    // Reset during the completing cycle of a write: no RAM update.
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = base[1] + 32'h08; pwdata[1] = 32'h1234_5678;
    @(negedge clk);
    penable[1] = 1'b1;
    for (int w = 0; w < 40 && pready[1] !== 1'b1; w++) @(negedge clk);
    check("pre_rst_ready", 64'(pready[1]), 64'(1));
    rstn = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_pready", 64'(pready[i]), 64'(0));
      check("midrst_pslverr", 64'(pslverr[i]), 64'(0));
      check("midrst_prdata", 64'(prdata[i]), 64'(0));
      last[i] = 32'h0;
    end
    @(negedge clk);
    rstn = 1'b1;
    xfer(1, 0, base[1] + 32'h08, 32'h0, 4'hF);
    idle(1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
